// File: rtl/axi4_frame_reader_if.sv
// axi4_frame_reader_if: AXI4 read address and read data channels between the frame reader and DDR.
interface axi4_frame_reader_if #(
   parameter int AW = 32,
   parameter int DW = 64
);
   logic [AW-1:0] ARADDR;
   logic          ARVALID;
   logic          ARREADY;
   logic [7:0]    ARLEN;
   logic [2:0]    ARSIZE;
   logic [1:0]    ARBURST;
   logic [3:0]    ARCACHE;
   logic [2:0]    ARPROT;
   logic [DW-1:0] RDATA;
   logic          RVALID;
   logic          RREADY;
   logic          RLAST;
   logic [1:0]    RRESP;
   modport master (
      output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
      input  ARREADY, RDATA, RVALID, RLAST, RRESP
   );
   modport slave (
      input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
      output ARREADY, RDATA, RVALID, RLAST, RRESP
   );
endinterface

// File: rtl/axi4_frame_reader.sv
// axi4_frame_reader: reads one frame from DDR as fixed INCR bursts and streams the beats into the scan-out FIFO.
// Define FRAME_LOOP_EN for continuous scan-out: each frame end restarts at a freshly latched base.
module axi4_frame_reader #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int BURST_LEN      = 16,
   parameter int FRAME_BYTES    = 614400
)(
   input  logic                      clk_100Mhz,
   input  logic                      rst,
   input  logic                      frame_start,
   input  logic [31:0]               FRAME_BASE_ADDR,
   axi4_frame_reader_if.master       axi,
   input  logic                      fifo_prog_full,
   output logic [AXI_DATA_WIDTH-1:0] o_wr_data,
   output logic                      o_wr_en,
   output logic                      frame_busy,
   output logic                      frame_done,
   output logic                      err_flag,
   output logic [1:0]                state,
   output logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET
);
`ifdef FRAME_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * AXI_DATA_WIDTH / 8);
   localparam logic [AXI_ADDR_WIDTH-1:0] FRAME_SZ    = AXI_ADDR_WIDTH'(FRAME_BYTES);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_AR = 2'd1, S_R = 2'd2, S_WAIT = 2'd3} state_t;

   state_t                    r_state, w_next;
   logic [AXI_ADDR_WIDTH-1:0] r_base, r_offset, w_new_off;
   logic [BW-1:0]             r_beat;
   logic [AXI_DATA_WIDTH-1:0] r_wr_data;
   logic                      r_wr_en, r_busy, r_done, r_err;
   logic                      w_beat, w_last_idx, w_end, w_frame_end, w_start;

   assign w_start     = (r_state == S_IDLE) && frame_start;
   assign w_beat      = (r_state == S_R) && axi.RVALID;
   assign w_last_idx  = r_beat == BW'(BURST_LEN - 1);
   // A burst ends on RLAST or on the final beat index, whichever comes first.
   assign w_end       = w_beat && (axi.RLAST || w_last_idx);
   assign w_new_off   = r_offset + BURST_BYTES;
   assign w_frame_end = w_new_off == FRAME_SZ;

   always_ff @(posedge clk_100Mhz or posedge rst)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = frame_start ? S_WAIT : S_IDLE;
         S_WAIT:  w_next = fifo_prog_full ? S_WAIT : S_AR;
         S_AR:    w_next = axi.ARREADY ? S_R : S_AR;
         default: w_next = !w_end ? S_R : (w_frame_end && !LOOP) ? S_IDLE : S_WAIT;
      endcase
   end

   always_ff @(posedge clk_100Mhz or posedge rst)
      if (rst) begin
         r_base    <= '0;
         r_offset  <= '0;
         r_beat    <= '0;
         r_wr_data <= '0;
         r_wr_en   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_wr_en <= w_beat;
         r_done  <= w_end && w_frame_end;
         if (w_beat) r_wr_data <= axi.RDATA;
         if (w_beat) r_beat <= w_end ? '0 : r_beat + 1'b1;
         if (w_beat && ((axi.RLAST != w_last_idx) || (axi.RRESP != 2'b00))) r_err <= 1'b1;
         if (w_start) begin
            r_base   <= AXI_ADDR_WIDTH'(FRAME_BASE_ADDR);
            r_offset <= '0;
            r_busy   <= 1'b1;
         end
         if (w_end) r_offset <= w_frame_end ? '0 : w_new_off;
         if (w_end && w_frame_end) begin
            r_busy <= LOOP;
            r_base <= LOOP ? AXI_ADDR_WIDTH'(FRAME_BASE_ADDR) : r_base;
         end
      end

   assign axi.ARADDR  = r_base + r_offset;
   assign axi.ARVALID = r_state == S_AR;
   assign axi.ARLEN   = 8'(BURST_LEN - 1);
   assign axi.ARSIZE  = 3'b011;
   assign axi.ARBURST = 2'b01;
   assign axi.ARCACHE = 4'b0011;
   assign axi.ARPROT  = 3'b000;
   assign axi.RREADY  = r_state == S_R;
   assign o_wr_data   = r_wr_data;
   assign o_wr_en     = r_wr_en;
   assign frame_busy  = r_busy;
   assign frame_done  = r_done;
   assign err_flag    = r_err;
   assign state       = r_state;
   assign ADDR_OFFSET = r_offset;
endmodule

// File: tb/tb_axi4_frame_reader.sv
// tb_axi4_frame_reader: randomized AXI slave with a queue scoreboard for the frame reader (4-burst frames).
module tb_axi4_frame_reader;
   localparam int BL = 16;
   localparam int FB = 512;
   localparam int BB = BL * 8;
   localparam int NB = FB / BB;
`ifdef FRAME_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b1, frame_start = 1'b0, fifo_prog_full = 1'b0;
   logic [31:0] base_in = '0;
   logic [63:0] wr_data;
   logic        wr_en, busy, done, err;
   logic [1:0]  st;
   logic [31:0] off;

   axi4_frame_reader_if #(.AW(32), .DW(64)) axi();

   axi4_frame_reader #(
      .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .BURST_LEN(BL), .FRAME_BYTES(FB)
   ) dut (
      .clk_100Mhz(clk), .rst(rst), .frame_start(frame_start), .FRAME_BASE_ADDR(base_in),
      .axi(axi), .fifo_prog_full(fifo_prog_full), .o_wr_data(wr_data), .o_wr_en(wr_en),
      .frame_busy(busy), .frame_done(done), .err_flag(err), .state(st), .ADDR_OFFSET(off)
   );

   always #5 clk = ~clk;

   int          errors = 0, checks = 0, done_cnt = 0, wr_cnt = 0, iss_cnt = 0;
   bit          exp_err = 1'b0;
   logic [31:0] exp_ar[$];
   logic [63:0] exp_wr[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // Scoreboard monitor: pops expectations whenever the DUT presents an AR handshake or a FIFO write.
   always @(negedge clk) if (!rst) begin
      if (axi.ARVALID && axi.ARREADY) begin
         if (exp_ar.size() == 0) fail("unexpected_ar");
         else chk("araddr", axi.ARADDR, exp_ar.pop_front());
         chk("arlen", axi.ARLEN, 64'd15);
      end
      if (wr_en) begin
         wr_cnt++;
         if (exp_wr.size() == 0) fail("unexpected_wr");
         else chk("wr_data", wr_data, exp_wr.pop_front());
      end
      if (done) done_cnt++;
      if (st == 2'd2) chk("r_state_bus", {axi.ARVALID, axi.RREADY}, 2'b01);
   end

   task automatic check_cleared(input string tag);
      chk({tag, "_flags"}, {axi.ARVALID, axi.RREADY, wr_en, busy, done, err, st}, '0);
      chk({tag, "_offset"}, off, '0);
      chk({tag, "_araddr"}, axi.ARADDR, '0);
      chk({tag, "_wr_data"}, wr_data, '0);
      chk({tag, "_ar_const"}, {axi.ARSIZE, axi.ARBURST, axi.ARCACHE, axi.ARPROT},
          {3'b011, 2'b01, 4'b0011, 3'b000});
   endtask

   task automatic do_reset;
      @(posedge clk); #1;
      rst = 1'b1;
      axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = 2'b00;
      fifo_prog_full = 1'b0; frame_start = 1'b0;
      #1 check_cleared("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_ar.delete(); exp_wr.delete();
      exp_err = 1'b0; done_cnt = 0; wr_cnt = 0; iss_cnt = 0;
   endtask

   task automatic start_frame(input logic [31:0] base);
      base_in = base;
      for (int k = 0; k < NB; k++) exp_ar.push_back(base + 32'(k * BB));
      frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      chk("busy_on_start", busy, 1);
   endtask

   task automatic do_burst(input int gap, input int rlast_beat, input int bad_beat,
                           input int pf, input int abort_beat);
      int          t = 0;
      logic [31:0] a;
      while (!axi.ARVALID && t < 100) begin @(posedge clk); #1; t++; end
      if (!axi.ARVALID) begin fail("ar_timeout"); return; end
      a = axi.ARADDR;
      repeat (2) begin @(posedge clk); #1; chk("ar_hold", {axi.ARVALID, axi.ARADDR}, {1'b1, a}); end
      axi.ARREADY = 1'b1;
      @(posedge clk); #1 axi.ARREADY = 1'b0;
      if (pf > 0) fifo_prog_full = 1'b1;
      for (int i = 0; i < BL; i++) begin
         repeat (gap) begin axi.RVALID = 1'b0; @(posedge clk); #1; end
         axi.RVALID = 1'b1;
         axi.RDATA  = {$urandom, $urandom};
         axi.RLAST  = (i == rlast_beat);
         axi.RRESP  = (i == bad_beat) ? 2'b10 : 2'b00;
         chk("rready", axi.RREADY, 1);
         exp_wr.push_back(axi.RDATA);
         iss_cnt++;
         if ((i == bad_beat) || ((i == rlast_beat) != (i == BL - 1))) exp_err = 1'b1;
         if (i == abort_beat) begin
            #5 rst = 1'b1;
            #1 check_cleared("abort");
            exp_ar.delete(); exp_wr.delete();
            axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = 2'b00;
            return;
         end
         @(posedge clk); #1;
         if (i == rlast_beat) break;
      end
      axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = 2'b00;
      if (pf > 0) begin
         repeat (pf) begin @(posedge clk); #1; chk("pf_wait", {st, axi.ARVALID}, {2'd3, 1'b0}); end
         fifo_prog_full = 1'b0;
         @(posedge clk); #1 chk("ar_after_pf", axi.ARVALID, 1);
      end
   endtask

   task automatic finish_frame(input string tag);
      @(negedge clk); #1;
      chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      chk({tag, "_busy"}, busy, LOOP);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_wr_cnt"}, 64'(wr_cnt), 64'(iss_cnt));
      chk({tag, "_queues"}, {32'(exp_ar.size()), 32'(exp_wr.size())}, '0);
      chk({tag, "_offset"}, off, '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = 2'b00; axi.RDATA = '0;
      do_reset;
      start_frame(32'h1000_0000);
      do_burst(0, 15, -1, 50, -1);
      for (int k = 1; k < NB; k++) do_burst(0, 15, -1, 0, -1);
      finish_frame("clean");

      do_reset;
      start_frame(32'h1000_0000);
      do_burst(2, 15, -1, 0, -1);
      base_in = 32'h3000_0000;
      frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      base_in = 32'h1000_0000;
      for (int k = 1; k < NB; k++) do_burst(2, 15, -1, 0, -1);
      finish_frame("gaps");

      do_reset;
      start_frame(32'h1000_0000);
      do_burst(0, 10, -1, 0, -1);
      chk("early_err", err, 1);
      chk("early_offset", off, 32'h80);
      for (int k = 1; k < NB; k++) do_burst(0, 15, -1, 0, -1);
      finish_frame("early_rlast");

      do_reset;
      start_frame(32'h1000_0000);
      do_burst(0, 15, 5, 0, -1);
      for (int k = 1; k < NB; k++) do_burst(0, 15, -1, 0, -1);
      finish_frame("bad_resp");

      do_reset;
      start_frame(32'h1000_0000);
      do_burst(0, 15, -1, 0, -1);
      do_burst(0, 99, -1, 0, -1);
      for (int k = 2; k < NB; k++) do_burst(0, 15, -1, 0, -1);
      finish_frame("missing_rlast");

      do_reset;
      start_frame(32'h1000_0000);
      do_burst(0, 15, -1, 0, 7);
      do_reset;
      start_frame(32'h1000_0000);
      for (int k = 0; k < NB; k++) do_burst($urandom_range(0, 1), 15, -1, 0, -1);
      finish_frame("after_abort");

`ifdef FRAME_LOOP_EN
      do_reset;
      start_frame(32'h1000_0000);
      exp_ar.push_back(32'h2000_0000);
      do_burst(0, 15, -1, 0, -1);
      base_in = 32'h2000_0000;
      for (int k = 1; k < NB; k++) do_burst(0, 15, -1, 0, -1);
      @(negedge clk); #1;
      chk("loop_done_cnt", 64'(done_cnt), 64'd1);
      chk("loop_busy", busy, 1);
      do_burst(0, 15, -1, 0, -1);
      @(negedge clk); #1;
      chk("loop_queues", {32'(exp_ar.size()), 32'(exp_wr.size())}, '0);
`endif
      do_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
